cpu_mult_unit: RTL
==================

Name: cpu_mult_unit

Overview:
- Parametrised, handshaked integer multiplier for the soft CPU's M/W stages; successor to the fixed 32-bit, three-partial-product mult cell.
- Produces the full 2*DATA_W product internally, with per-operation signedness (mul, mulxss, mulxsu, mulxuu).
- Pipelined with PIPE_STAGES register stages, valid/ready flow control, flush, and a destination tag carried alongside each operation.

Parameters:
DATA_W, 32, operand width; multiple of 16, legal range 16..64
PIPE_STAGES, 2, register stages from accept to result; legal range 1..4
TAG_W, 5, width of the pass-through tag (destination register index)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  kill all in-flight operations (synchronous)
in_valid  in  1  operation offered
in_ready  out  1  operation accepted when in_valid && in_ready
in_a  in  DATA_W  operand A
in_b  in  DATA_W  operand B
in_op  in  2  00 mul (lo, any sign), 01 mulxss, 10 mulxsu (A signed, B unsigned), 11 mulxuu
in_tag  in  TAG_W  tag, returned unchanged with the result
out_valid  out  1  result available
out_ready  in  1  consumer accepts when out_valid && out_ready
out_result  out  DATA_W  lo word for op 00, hi word otherwise
out_lo  out  DATA_W  product bits [DATA_W-1:0]
out_hi  out  DATA_W  product bits [2*DATA_W-1:DATA_W]
out_tag  out  TAG_W  tag of the presented result

Behaviour:
- Reset (async, active-high): all stage valid bits are 0. out_valid=0; out_result, out_lo, out_hi, out_tag = 0; in_ready=1 once reset deasserts.
- Stall enable: en = !out_valid || out_ready. in_ready = en. All stages advance together only when en=1. No bubble collapsing; data and valid bits hold while en=0.
- Latency: an operation accepted at edge N is presented with out_valid=1 after edge N+PIPE_STAGES-1 (PIPE_STAGES cycles of register delay, counting the accepting edge), provided no stall occurs. Throughput is 1 op/cycle.
- Arithmetic:
  - Each operand is extended to DATA_W+1 bits: sign-extended when treated as signed, zero-extended otherwise. For op 00 both are zero-extended; the lo word is identical either way.
  - The product is formed from 16x16 partial products. The partial-product sum is split at stage 1; final accumulation and sign correction complete in the last stage.
  - Result is exact modulo 2^(2*DATA_W).
- Operation order: results emerge in issue order; out_tag always matches its result.
- Flush: on an edge with flush=1, all stage valid bits clear regardless of en, and any in_valid on that edge is not accepted (in_ready forced 0 while flush=1). Data registers need not clear. out_valid=0 the following cycle.
- Simultaneous events:
  - flush with out_valid && out_ready: the presented result counts as consumed. flush wins for everything else.
  - Reset mid-operation: all in-flight operations are discarded, with no spurious out_valid.
- Stall boundary: while out_valid=1 && out_ready=0, out_* stays stable and in_ready=0. A new operation is accepted on the same edge the stalled result is consumed.
- PIPE_STAGES=1: combinational multiply into a single output register. in_ready = !out_valid || out_ready still applies.

Test Plan:
- DATA_W=32, op 11, A=B=0xFFFFFFFF -> after PIPE_STAGES cycles out_hi=0xFFFFFFFE, out_lo=0x00000001, out_result=0xFFFFFFFE.
- op 01 with A=B=0xFFFFFFFF -> out_hi=0x00000000, out_lo=0x00000001. op 10 with A=B=0xFFFFFFFF -> out_hi=0xFFFFFFFF, out_lo=0x00000001.
- A=B=0x80000000: op 01 -> out_hi=0x40000000; op 10 -> out_hi=0xC0000000; op 00 -> out_result=0x00000000.
- Back-to-back stream of 8 ops with tags 0..7, out_ready held low for 3 cycles mid-stream -> outputs stable during the stall, in_ready=0, all 8 results in order with correct tags, none lost or duplicated.
- Issue 2 ops, assert flush 1 cycle before the first would emerge -> neither result appears. An op issued the cycle after flush returns normally.
- Assert reset with 2 ops in flight, release -> out_valid=0 and outputs=0 during reset. The first op after release returns with correct latency. Repeat with DATA_W=64, PIPE_STAGES=3 on random signed/unsigned vectors against a reference model.

Source files
------------

// File: rtl/cpu_mult_unit.sv
// cpu_mult_unit
//   Parametrised, handshaked integer multiplier for the soft CPU's M/W stages.
//   Builds the full 2*DATA_W product from 16x16 partial products, with a
//   per-operation signedness select, a pipeline of PIPE_STAGES register
//   stages, valid/ready flow control, flush, and a pass-through tag.
//
// Ports
//   clk        clock, all state on rising edge
//   reset      asynchronous, active-high reset
//   flush      kills every in-flight operation on the next edge
//   in_valid   operation offered
//   in_ready   operation accepted when in_valid && in_ready
//   in_a/in_b  operands
//   in_op      00 mul (lo), 01 mulxss, 10 mulxsu, 11 mulxuu
//   in_tag     tag returned unchanged with the result
//   out_valid  result available
//   out_ready  consumer accepts when out_valid && out_ready
//   out_result lo word for op 00, hi word otherwise
//   out_lo     product bits [DATA_W-1:0]
//   out_hi     product bits [2*DATA_W-1:DATA_W]
//   out_tag    tag of the presented result
module cpu_mult_unit #(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [1:0]        in_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_lo,
  output logic [DATA_W-1:0] out_hi,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int PW = 2 * DATA_W;
  localparam int NL = DATA_W / 16;

  logic en;
  logic accept;

  assign en       = !out_valid || out_ready;
  assign in_ready = en && !flush;
  assign accept   = in_valid && in_ready;

  // Operands are treated as unsigned limbs; a signed operand with its MSB set
  // is worth (unsigned value - 2^DATA_W). Expanding the product modulo
  // 2^(2*DATA_W), the 2^(2*DATA_W) cross term vanishes and only
  // (sa ? b : 0) + (sb ? a : 0) has to be subtracted at bit DATA_W.
  logic              sign_a;
  logic              sign_b;
  logic [31:0]       pp16;
  logic [PW-1:0]     pp_even;
  logic [PW-1:0]     pp_odd;
  logic [DATA_W-1:0] corr;

  always_comb begin
    sign_a  = ((in_op == 2'b01) || (in_op == 2'b10)) && in_a[DATA_W-1];
    sign_b  = (in_op == 2'b01) && in_b[DATA_W-1];
    corr    = (sign_a ? in_b : '0) + (sign_b ? in_a : '0);
    pp16    = '0;
    pp_even = '0;
    pp_odd  = '0;
    // Partial products are split into two sums by the parity of the A limb;
    // the two halves are only combined in the last stage.
    for (int i = 0; i < NL; i++) begin
      for (int j = 0; j < NL; j++) begin
        pp16 = 32'(in_a[16*i +: 16]) * 32'(in_b[16*j +: 16]);
        if (i % 2 == 0) pp_even = pp_even + (PW'(pp16) << (16 * (i + j)));
        else            pp_odd  = pp_odd  + (PW'(pp16) << (16 * (i + j)));
      end
    end
  end

  // Inputs to the final (output) register stage
  logic              fin_valid;
  logic [PW-1:0]     fin_even;
  logic [PW-1:0]     fin_odd;
  logic [DATA_W-1:0] fin_corr;
  logic [1:0]        fin_op;
  logic [TAG_W-1:0]  fin_tag;

  generate
    if (PIPE_STAGES == 1) begin : g_single
      assign fin_valid = accept;
      assign fin_even  = pp_even;
      assign fin_odd   = pp_odd;
      assign fin_corr  = corr;
      assign fin_op    = in_op;
      assign fin_tag   = in_tag;
    end else begin : g_pipe
      localparam int NS = PIPE_STAGES - 1;

      logic              s_valid [NS];
      logic [PW-1:0]     s_even  [NS];
      logic [PW-1:0]     s_odd   [NS];
      logic [DATA_W-1:0] s_corr  [NS];
      logic [1:0]        s_op    [NS];
      logic [TAG_W-1:0]  s_tag   [NS];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < NS; k++) s_valid[k] <= 1'b0;
        end else if (flush) begin
          for (int k = 0; k < NS; k++) s_valid[k] <= 1'b0;
        end else if (en) begin
          s_valid[0] <= accept;
          for (int k = 1; k < NS; k++) s_valid[k] <= s_valid[k-1];
        end
      end

      // Payload needs no reset; it is qualified by the valid bits.
      always_ff @(posedge clk) begin
        if (en) begin
          s_even[0] <= pp_even;
          s_odd[0]  <= pp_odd;
          s_corr[0] <= corr;
          s_op[0]   <= in_op;
          s_tag[0]  <= in_tag;
          for (int k = 1; k < NS; k++) begin
            s_even[k] <= s_even[k-1];
            s_odd[k]  <= s_odd[k-1];
            s_corr[k] <= s_corr[k-1];
            s_op[k]   <= s_op[k-1];
            s_tag[k]  <= s_tag[k-1];
          end
        end
      end

      assign fin_valid = s_valid[NS-1];
      assign fin_even  = s_even[NS-1];
      assign fin_odd   = s_odd[NS-1];
      assign fin_corr  = s_corr[NS-1];
      assign fin_op    = s_op[NS-1];
      assign fin_tag   = s_tag[NS-1];
    end
  endgenerate

  logic [PW-1:0] fin_prod;
  assign fin_prod = fin_even + fin_odd - {fin_corr, {DATA_W{1'b0}}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_lo     <= '0;
      out_hi     <= '0;
      out_tag    <= '0;
    end else begin
      if (flush)   out_valid <= 1'b0;
      else if (en) out_valid <= fin_valid;
      if (en) begin
        out_lo     <= fin_prod[DATA_W-1:0];
        out_hi     <= fin_prod[PW-1:DATA_W];
        out_result <= (fin_op == 2'b00) ? fin_prod[DATA_W-1:0] : fin_prod[PW-1:DATA_W];
        out_tag    <= fin_tag;
      end
    end
  end

endmodule
